sprite_palette_bank: RTL and testbench
======================================

# sprite_palette_bank

Runtime-writable, multi-bank colour palette for sprite rendering. It replaces per-sprite fixed palette ROMs with one parametrised block that maps a (bank, index) pair to 12-bit RGB through a 2-stage pipeline. It also flags the transparent colour key and applies a frame-synchronous hit-flash override. It sits between each sprite's index ROM and the VGA colour mux.

## Interface

Parameters:
- IDX_W, 4: palette index width; 2^IDX_W entries per bank.
- BANKS, 4: number of palette banks; bank select width is BANK_W = max(1, clog2(BANKS)).
- CH_W, 4: bits per colour channel.
- TRANSPARENT_IDX, 0: index treated as transparent key in every bank.
- FLASH_RGB, 12'hFFF: override colour during flash-on phase, {r,g,b}, CH_W bits each.

Ports:
- Clk, in, 1: single clock.
- Reset, in, 1: synchronous, active-high.
- wr_en, in, 1: palette write strobe.
- wr_bank, in, BANK_W: write bank.
- wr_idx, in, IDX_W: write entry.
- wr_rgb, in, 3*CH_W: write data {r,g,b}.
- rd_valid, in, 1: lookup request.
- rd_bank, in, BANK_W: lookup bank.
- rd_idx, in, IDX_W: lookup index.
- frame_tick, in, 1: one-cycle pulse per frame (vsync edge).
- flash_start, in, 1: start or restart flash.
- flash_frames, in, 8: total flash frames, sampled on flash_start.
- out_valid, out, 1: lookup result valid.
- red, green, blue, out, CH_W each: result colour.
- transparent, out, 1: result is the colour key; the sprite pixel is not drawn.
- flash_active, out, 1: flash FSM not IDLE.

## Operation

- Storage: BANKS × 2^IDX_W registers of 3*CH_W bits.
- On Reset, every bank loads DEFAULT_PALETTE. Entries beyond the table are 0.
- A write commits on the edge where wr_en=1. wr_bank ≥ BANKS is ignored.
- Stage 1 registers the entry read, s1_valid = rd_valid, and s1_key = (rd_idx == TRANSPARENT_IDX).
- If rd_bank ≥ BANKS, stage 1 yields rgb 0 with the key forced to 1.
- Stage 2 registers the outputs. If flash phase is ON and the key is 0, the rgb is replaced by FLASH_RGB. Transparent pixels stay transparent.
- Flash FSM states are IDLE, ON and OFF.
  - flash_start with flash_frames > 0: go to ON with rem = flash_frames, from any state. This is a restart.
  - flash_start with flash_frames = 0: go to IDLE.
  - On frame_tick in ON or OFF: rem−1. If the new rem is 0, go to IDLE; otherwise toggle ON↔OFF.
  - If flash_start and frame_tick arrive together, flash_start wins and the tick is not applied.
- Reset values: out_valid 0, red/green/blue 0, transparent 0, flash_active 0, FSM IDLE, rem 0.
- A Reset during a flash or mid-pipeline clears everything in that cycle. No partial result is emitted.

## Timing

- Lookup latency is 2 cycles: rd_valid at cycle N gives out_valid at N+2, one result per cycle, no stalls.
- Read-during-write to the same entry in the same cycle returns the old data. The new data is visible to a read issued at N+1.
- Flash override uses the FSM state at the stage-2 edge. A pixel in stage 1 when the FSM changes takes the new phase.
- flash_active rises 1 cycle after flash_start and falls 1 cycle after the terminating frame_tick.
- When out_valid=0, colour outputs hold their previous values.

## Structure

- Package palette_pkg holds:
  - flash_state_t enum {IDLE, ON, OFF}.
  - rgb12_t.
  - DEFAULT_PALETTE, a 16×12-bit localparam table (entry 0 is the transparent key colour).
  - FLASH_RGB default.
- Sub-module palette_flash_fsm contains the flash counter and FSM. Its outputs are flash_on and flash_active.

## Test plan

- Reset, then look up bank 0 idx 3: expect out_valid at +2 with DEFAULT_PALETTE[3] and transparent=0. Look up idx 0: expect transparent=1.
- Write bank 2 idx 5 = 12'h123 and issue a read of the same entry in the same cycle: expect the old value. Read again next cycle: expect 12'h123. Bank 0 idx 5 is unchanged.
- Pulse flash_start with flash_frames=3 and stream lookups of idx 4: expect FLASH_RGB, then the normal colour, then FLASH_RGB across frame ticks. Expect IDLE and flash_active=0 after the 3rd tick. Idx 0 stays transparent throughout.
- Pulse flash_start in the same cycle as frame_tick, with flash_frames=2: expect ON with rem=2 (the tick is ignored). A restart mid-flash reloads rem.
- Write to wr_bank=BANKS (with BANKS=3): no entry changes. A read from rd_bank=3 returns rgb 0 with transparent=1.
- Assert Reset mid-flash while the pipeline is full: next cycle out_valid=0, flash_active=0, and a modified entry has reverted to its default.

Source files
------------

// File: rtl/palette_pkg.sv
// palette_pkg
// Shared types and constants for the sprite palette bank.
//   flash_state_t   : flash FSM states (IDLE, ON, OFF)
//   rgb12_t         : packed 12-bit {r,g,b} colour, 4 bits per channel
//   DEFAULT_PALETTE : 16-entry colour table loaded into every bank on reset;
//                     entry 0 is the colour-key slot
//   FLASH_RGB_DEFAULT : default override colour used while a flash is ON
//   default_entry() : table lookup that yields 0 for entries past the table
package palette_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } flash_state_t;

    typedef logic [11:0] rgb12_t;

    localparam rgb12_t DEFAULT_PALETTE [16] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hF80, 12'h8F0,
        12'h08F, 12'hF08, 12'h8F8, 12'hCCC
    };

    localparam rgb12_t FLASH_RGB_DEFAULT = 12'hFFF;

    // Palettes wider than 16 entries get black in the slots the table does
    // not cover, so a larger IDX_W still comes out of reset deterministic.
    function automatic rgb12_t default_entry(input int idx);
        rgb12_t entry;
        entry = '0;
        if (idx >= 0 && idx < 16) begin
            entry = DEFAULT_PALETTE[idx[3:0]];
        end
        return entry;
    endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// palette_flash_fsm
// Frame-counted hit-flash sequencer. A start request loads the frame count
// and enters ON; each frame tick counts down one frame and alternates
// between ON and OFF until the count runs out.
// Ports:
//   clk          : clock
//   reset        : synchronous, active-high
//   frame_tick   : one-cycle pulse per frame
//   flash_start  : start or restart a flash
//   flash_frames : total frames in the flash, sampled with flash_start
//   flash_on     : override phase is active
//   flash_active : a flash is in progress (state not IDLE)
module palette_flash_fsm
    import palette_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       flash_start,
    input  logic [7:0] flash_frames,
    output logic       flash_on,
    output logic       flash_active
);

    flash_state_t state;
    flash_state_t state_next;
    logic [7:0]   rem;
    logic [7:0]   rem_next;
    logic [7:0]   rem_dec;

    // State and remaining-frame registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= 8'd0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // Next-state logic. A start request takes priority over a coincident
    // frame tick, so a restart on a tick edge begins with the full count
    // rather than losing a frame. A zero-length start request cancels any
    // flash in progress.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        rem_dec    = rem - 8'd1;
        if (flash_start) begin
            if (flash_frames != 8'd0) begin
                state_next = ON;
                rem_next   = flash_frames;
            end else begin
                state_next = IDLE;
                rem_next   = 8'd0;
            end
        end else if (frame_tick && state != IDLE) begin
            rem_next = rem_dec;
            if (rem_dec == 8'd0) begin
                state_next = IDLE;
            end else if (state == ON) begin
                state_next = OFF;
            end else begin
                state_next = ON;
            end
        end
    end

    assign flash_on     = (state == ON);
    assign flash_active = (state != IDLE);

endmodule

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
// Runtime-writable multi-bank palette. Maps (bank, index) to {r,g,b} through
// a two-stage pipeline, flags the colour key as transparent, and overrides
// opaque pixels with a flash colour during the ON phase of a hit flash.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wr_en, wr_bank, wr_idx,
//   wr_rgb                     : palette entry write (out-of-range bank ignored)
//   rd_valid, rd_bank, rd_idx  : lookup request, result two cycles later
//   frame_tick                 : one-cycle pulse per frame
//   flash_start, flash_frames  : start/restart a flash of flash_frames frames
//   out_valid                  : lookup result valid
//   red, green, blue           : result colour, held while out_valid is low
//   transparent                : result is the colour key, pixel not drawn
//   flash_active               : a flash is in progress
module sprite_palette_bank
    import palette_pkg::*;
#(
    parameter int IDX_W           = 4,
    parameter int BANKS           = 4,
    parameter int CH_W            = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter logic [3*CH_W-1:0] FLASH_RGB = (3*CH_W)'(FLASH_RGB_DEFAULT),
    localparam int BANK_W         = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [3*CH_W-1:0]   wr_rgb,
    input  logic                rd_valid,
    input  logic [BANK_W-1:0]   rd_bank,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic                frame_tick,
    input  logic                flash_start,
    input  logic [7:0]          flash_frames,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                transparent,
    output logic                flash_active
);

    localparam int RGB_W   = 3 * CH_W;
    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]  KEY_IDX    = IDX_W'(TRANSPARENT_IDX);
    localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(BANKS);

    logic [RGB_W-1:0] mem [BANKS][ENTRIES];

    logic             wr_ok;
    logic             rd_ok;
    logic             flash_on;

    logic             s1_valid;
    logic [RGB_W-1:0] s1_rgb;
    logic             s1_key;
    logic [RGB_W-1:0] out_rgb;

    // Bank selects are one bit wider in the comparison so that a
    // non-power-of-two bank count can reject the unused codes.
    assign wr_ok = ({1'b0, wr_bank} < BANK_LIMIT);
    assign rd_ok = ({1'b0, rd_bank} < BANK_LIMIT);

    // Palette storage. Every bank reloads the default table on reset so a
    // reset mid-game also discards any runtime recolouring.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    mem[b][e] <= RGB_W'(default_entry(e));
                end
            end
        end else if (wr_en && wr_ok) begin
            mem[wr_bank][wr_idx] <= wr_rgb;
        end
    end

    // Stage 1: entry read and colour-key compare. The read sees the storage
    // before any same-cycle write lands, so read-during-write returns the
    // old colour. A bank outside the palette reads as a transparent black
    // pixel so a bad bank select never draws garbage.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_rgb   <= '0;
            s1_key   <= 1'b0;
        end else begin
            s1_valid <= rd_valid;
            if (rd_ok) begin
                s1_rgb <= mem[rd_bank][rd_idx];
                s1_key <= (rd_idx == KEY_IDX);
            end else begin
                s1_rgb <= '0;
                s1_key <= 1'b1;
            end
        end
    end

    // Stage 2: output register with flash override. The flash phase is taken
    // from the FSM at this edge, so a pixel already in stage 1 when the
    // phase changes picks up the new phase. Colour-key pixels are never
    // flashed. Outputs hold between valid results.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_rgb     <= '0;
            transparent <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                transparent <= s1_key;
                out_rgb     <= (flash_on && !s1_key) ? FLASH_RGB : s1_rgb;
            end
        end
    end

    palette_flash_fsm u_flash (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .flash_start  (flash_start),
        .flash_frames (flash_frames),
        .flash_on     (flash_on),
        .flash_active (flash_active)
    );

    assign red   = out_rgb[3*CH_W-1:2*CH_W];
    assign green = out_rgb[2*CH_W-1:CH_W];
    assign blue  = out_rgb[CH_W-1:0];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank
// Bench for sprite_palette_bank built with three banks so the unused bank
// code can be exercised. Lookups push their expected colour, key flag and
// arrival cycle onto a queue; the queue is drained as results appear.
module tb_sprite_palette_bank;

    logic        clk;
    logic        reset;
    logic        wrEn;
    logic [1:0]  wrBank;
    logic [3:0]  wrIdx;
    logic [11:0] wrRgb;
    logic        rdValid;
    logic [1:0]  rdBank;
    logic [3:0]  rdIdx;
    logic        frameTick;
    logic        flashStart;
    logic [7:0]  flashFrames;
    logic        outValid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        transparent;
    logic        flashActive;

    typedef struct {
        logic [11:0] rgb;
        logic        key;
        int          cyc;
    } expItem_t;

    expItem_t sbQueue [$];

    int errors;
    int checks;
    int cycleCount;

    localparam logic [11:0] defPal [16] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hF80, 12'h8F0,
        12'h08F, 12'hF08, 12'h8F8, 12'hCCC
    };
    localparam logic [11:0] flashColour = 12'hFFF;

    sprite_palette_bank #(
        .IDX_W           (4),
        .BANKS           (3),
        .CH_W            (4),
        .TRANSPARENT_IDX (0),
        .FLASH_RGB       (12'hFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wrEn),
        .wr_bank      (wrBank),
        .wr_idx       (wrIdx),
        .wr_rgb       (wrRgb),
        .rd_valid     (rdValid),
        .rd_bank      (rdBank),
        .rd_idx       (rdIdx),
        .frame_tick   (frameTick),
        .flash_start  (flashStart),
        .flash_frames (flashFrames),
        .out_valid    (outValid),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .transparent  (transparent),
        .flash_active (flashActive)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Queues a lookup for the next edge and records what must come out two
    // cycles later.
    task automatic issueRead(input logic [1:0] b, input logic [3:0] i,
                             input logic [11:0] e, input logic k);
        expItem_t it;
        rdValid = 1'b1;
        rdBank  = b;
        rdIdx   = i;
        it.rgb  = e;
        it.key  = k;
        it.cyc  = cycleCount + 2;
        sbQueue.push_back(it);
    endtask

    // Advances one clock, releases the one-cycle strobes and retires any
    // lookup result against the queue.
    task automatic stepClock();
        expItem_t it;
        @(posedge clk);
        #1;
        cycleCount++;
        rdValid    = 1'b0;
        wrEn       = 1'b0;
        frameTick  = 1'b0;
        flashStart = 1'b0;
        if (outValid) begin
            checks++;
            if (sbQueue.size() == 0) begin
                errors++;
                $display("[TB] FAIL lookup_unexpected: out_valid=1 with nothing outstanding at cycle %0d", cycleCount);
            end else begin
                it = sbQueue.pop_front();
                if ({red, green, blue} !== it.rgb || transparent !== it.key || cycleCount != it.cyc) begin
                    errors++;
                    $display("[TB] FAIL lookup: got rgb=%h key=%b cycle=%0d, expected rgb=%h key=%b cycle=%0d",
                             {red, green, blue}, transparent, cycleCount, it.rgb, it.key, it.cyc);
                end
            end
        end else if (sbQueue.size() != 0 && sbQueue[0].cyc <= cycleCount) begin
            checks++;
            errors++;
            it = sbQueue.pop_front();
            $display("[TB] FAIL lookup_missing: out_valid=0 at cycle %0d, expected rgb=%h key=%b", cycleCount, it.rgb, it.key);
        end
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            stepClock();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stepClock();
        stepClock();
        reset = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", outValid);
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_rgb: got %h expected 000", {red, green, blue});
        end
        checks++;
        if (transparent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_transparent: got %b expected 0", transparent);
        end
        checks++;
        if (flashActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flash_active: got %b expected 0", flashActive);
        end
    endtask

    task automatic test_default_lookup();
        issueRead(2'd0, 4'd0, defPal[0], 1'b1);
        stepClock();
        issueRead(2'd0, 4'd3, defPal[3], 1'b0);
        stepClock();
        drain(3);
        checks++;
        if (outValid !== 1'b0 || {red, green, blue} !== defPal[3]) begin
            errors++;
            $display("[TB] FAIL hold_colour: got valid=%b rgb=%h expected valid=0 rgb=%h",
                     outValid, {red, green, blue}, defPal[3]);
        end
    endtask

    task automatic test_back_to_back();
        wrEn   = 1'b1;
        wrBank = 2'd2;
        wrIdx  = 4'd5;
        wrRgb  = 12'h123;
        issueRead(2'd2, 4'd5, defPal[5], 1'b0);
        stepClock();
        issueRead(2'd2, 4'd5, 12'h123, 1'b0);
        stepClock();
        issueRead(2'd0, 4'd5, defPal[5], 1'b0);
        stepClock();
        issueRead(2'd1, 4'd15, defPal[15], 1'b0);
        stepClock();
        drain(3);
    endtask

    task automatic test_flash();
        flashFrames = 8'd3;
        flashStart  = 1'b1;
        issueRead(2'd0, 4'd4, flashColour, 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flash_rise: got %b expected 1", flashActive);
        end
        issueRead(2'd0, 4'd0, defPal[0], 1'b1);
        stepClock();
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        issueRead(2'd0, 4'd0, defPal[0], 1'b1);
        stepClock();
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, flashColour, 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flash_mid: got %b expected 1", flashActive);
        end
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flash_end: got %b expected 0", flashActive);
        end
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        drain(3);
    endtask

    task automatic test_start_tick_collision();
        flashFrames = 8'd2;
        flashStart  = 1'b1;
        frameTick   = 1'b1;
        issueRead(2'd0, 4'd4, flashColour, 1'b0);
        stepClock();
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_tick_ignored: got %b expected 1", flashActive);
        end
        flashFrames = 8'd2;
        flashStart  = 1'b1;
        issueRead(2'd0, 4'd4, flashColour, 1'b0);
        stepClock();
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_reload: got %b expected 1", flashActive);
        end
        frameTick = 1'b1;
        issueRead(2'd0, 4'd4, defPal[4], 1'b0);
        stepClock();
        checks++;
        if (flashActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_end: got %b expected 0", flashActive);
        end
        flashFrames = 8'd5;
        flashStart  = 1'b1;
        stepClock();
        flashFrames = 8'd0;
        flashStart  = 1'b1;
        stepClock();
        checks++;
        if (flashActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_frames_cancel: got %b expected 0", flashActive);
        end
        drain(2);
    endtask

    task automatic test_bad_bank();
        wrEn   = 1'b1;
        wrBank = 2'd3;
        wrIdx  = 4'd6;
        wrRgb  = 12'hABC;
        stepClock();
        for (int b = 0; b < 3; b++) begin
            issueRead(b[1:0], 4'd6, defPal[6], 1'b0);
            stepClock();
        end
        issueRead(2'd3, 4'd6, 12'h000, 1'b1);
        stepClock();
        issueRead(2'd3, 4'd0, 12'h000, 1'b1);
        stepClock();
        drain(3);
    endtask

    task automatic test_reset_mid_flash();
        wrEn   = 1'b1;
        wrBank = 2'd1;
        wrIdx  = 4'd7;
        wrRgb  = 12'h555;
        stepClock();
        issueRead(2'd1, 4'd7, 12'h555, 1'b0);
        stepClock();
        flashFrames = 8'd4;
        flashStart  = 1'b1;
        issueRead(2'd1, 4'd2, flashColour, 1'b0);
        stepClock();
        issueRead(2'd1, 4'd7, flashColour, 1'b0);
        stepClock();
        rdValid = 1'b1;
        rdBank  = 2'd1;
        rdIdx   = 4'd3;
        reset   = 1'b1;
        sbQueue.delete();
        stepClock();
        reset = 1'b0;
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_out_valid: got %b expected 0", outValid);
        end
        checks++;
        if (flashActive !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flash_active: got %b expected 0", flashActive);
        end
        checks++;
        if ({red, green, blue} !== 12'h000 || transparent !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got rgb=%h key=%b expected rgb=000 key=0",
                     {red, green, blue}, transparent);
        end
        issueRead(2'd1, 4'd7, defPal[7], 1'b0);
        stepClock();
        issueRead(2'd2, 4'd5, defPal[5], 1'b0);
        stepClock();
        drain(3);
    endtask

    // Runs every scenario in order, then reports.
    initial begin
        errors      = 0;
        checks      = 0;
        cycleCount  = 0;
        reset       = 1'b0;
        wrEn        = 1'b0;
        wrBank      = 2'd0;
        wrIdx       = 4'd0;
        wrRgb       = 12'h000;
        rdValid     = 1'b0;
        rdBank      = 2'd0;
        rdIdx       = 4'd0;
        frameTick   = 1'b0;
        flashStart  = 1'b0;
        flashFrames = 8'd0;

        test_reset();
        test_default_lookup();
        test_back_to_back();
        test_flash();
        test_start_tick_collision();
        test_bad_bank();
        test_reset_mid_flash();

        if (sbQueue.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover_lookups: got %0d outstanding expected 0", sbQueue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
